mmio_bus_hub: RTL and testbench
===============================

// Module: mmio_bus_hub
// PURPOSE
//  Sits directly downstream of the CPU core's byte-wide memory bus (addr, wr, dout/din) and routes each access
//  to RAM or to the memory-mapped I/O space (addr[17:16]==2'b11).
//  Owns the UART TX/RX byte FIFOs, the free-running cycle counter (0x30004 read) and the program-stop flag (0x30004 write).
//  Drives io_buffer_full back to the CPU.
// PARAMETERS
//  RAM_AW        17  RAM byte-address width (128KB)
//  FIFO_LOG      3   log2 depth of each UART FIFO (depth 8)
// PORTS
//  clk_in        in   1   system clock
//  rst_in        in   1   synchronous, active-high reset
//  cpu_a         in   32  CPU address (only [17:0] decoded)
//  cpu_wr        in   1   1 = write this cycle, 0 = read
//  cpu_dout      in   8   CPU write data
//  cpu_din       out  8   read data for the access issued the previous cycle
//  io_full       out  1   TX FIFO near-full, to CPU io_buffer_full
//  ram_a         out  RAM_AW  RAM address (cpu_a[RAM_AW-1:0])
//  ram_wr        out  1   RAM write strobe (RAM space and cpu_wr only)
//  ram_dout      out  8   RAM write data
//  ram_din       in   8   RAM read data, valid one cycle after ram_a
//  tx_valid      out  1   TX FIFO head valid
//  tx_data       out  8   TX FIFO head byte
//  tx_ready      in   1   UART accepts head when tx_valid&tx_ready
//  rx_valid      in   1   UART pushes rx_data this cycle
//  rx_data       in   8   received byte
//  program_stop  out  1   sticky: 0x30004 written
//  tx_overflow   out  1   sticky: TX write dropped while full
// BEHAVIOUR
//  - Reset: all outputs 0, both FIFOs empty, cycle counter 0, snapshot 0, sticky flags 0, previous-access regs invalid.
//  - Decode: io = (cpu_a[17:16]==2'b11); otherwise RAM. ram_wr = cpu_wr & ~io; ram_a/ram_dout are combinational pass-through.
//  - Read latency 1: sel_q/addr_q are registered each cycle; cpu_din = RAM ? ram_din : io_rdata_q.
//  - IO read 0x30000: returns RX head, or 0x00 if empty. Pops the RX FIFO only on a new access, i.e. the first cycle
//    where (cpu_a, cpu_wr) differs from the previous cycle. Repeated identical read cycles return the same byte, no pop.
//  - IO read 0x30004: latches the counter into the snapshot (new-access rule) and returns snapshot[7:0].
//    Reads of 0x30005/6/7 return snapshot bytes 1/2/3 and never relatch.
//  - Cycle counter: 32-bit, +1 every cycle after reset, wraps 0xFFFFFFFF->0.
//  - IO write 0x30000: data != 0 pushes to TX; data == 0 is ignored. Push is gated by the new-access rule too.
//  - IO write 0x30004: sets program_stop and enqueues 0x00 to TX. If TX is full, stop_pending holds until one slot
//    frees, then pushes. A CPU push in that same cycle takes priority; stop_pending waits.
//  - Other IO addresses: writes ignored, reads return 0x00.
//  - TX FIFO: pointers FIFO_LOG+1 bits wide (wrap bit). Full when the count is 2^FIFO_LOG, empty when the count is 0.
//    io_full = count >= 2^FIFO_LOG-1, giving one slot of slack for the in-flight CPU write.
//    Push on full with no pop in the same cycle: byte dropped, tx_overflow set.
//    Simultaneous push and pop on full: both happen, count unchanged.
//  - RX FIFO: a push on full drops the byte silently. Simultaneous push and pop on empty: the pushed byte is stored,
//    and the read returns 0x00.
//  - tx_valid = ~tx_empty; tx_data = mem[rd_ptr]; pop on tx_valid&tx_ready.
//  - Reset mid-operation: FIFOs flushed, pending stop cleared, and the first access after reset counts as new.
// TESTING
//  1. Write 0x41 to 0x00100, then read 0x00100 -> ram_wr pulses one cycle; cpu_din=0x41 one cycle after the read address.
//  2. Write 0x48,0x00,0x49 to 0x30000 with tx_ready=1 -> tx emits 0x48 then 0x49; the 0x00 write is never enqueued.
//  3. tx_ready=0, 8 distinct writes -> io_full rises after the 7th; a 9th write is dropped; tx_overflow=1; count stays 8.
//  4. rx pushes 0x31,0x32; read 0x30000 held 3 cycles, then 0x0 for 1 cycle, then 0x30000 again ->
//     returns 0x31,0x31,0x31 then 0x32; afterwards the FIFO is empty and returns 0x00.
//  5. At counter=0x12345678, read 0x30004..0x30007 on consecutive cycles -> bytes 78,56,34,12 (snapshot, not live).
//  6. TX full, tx_ready=0, write 0x30004 -> program_stop=1 at once; after tx_ready=1 drains one byte, 0x00 is enqueued last.

Source files
------------

// File: rtl/mmio_bus_hub.sv
// mmio_bus_hub: routes CPU byte bus to RAM or MMIO (UART FIFOs, cycle counter, stop flag)
module mmio_bus_hub #(
  parameter int RAM_AW   = 17,
  parameter int FIFO_LOG = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       cpu_a,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              io_full,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              program_stop,
  output logic              tx_overflow
);
  localparam int D = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0] DEPTH = (FIFO_LOG+1)'(D);
  localparam logic [FIFO_LOG:0] ONE = (FIFO_LOG+1)'(1);
  logic [17:0] a;
  logic io, new_acc, io_rd, io_wr;
  logic [31:0] prev_a;
  logic prev_wr, prev_v;
  logic sel_q, v_q;
  logic [7:0] io_rdata_q, rd_data;
  logic [31:0] cnt, snap;
  logic [7:0] tx_mem [D];
  logic [7:0] rx_mem [D];
  logic [FIFO_LOG:0] tx_wp, tx_rp, tx_cnt, rx_wp, rx_rp, rx_cnt;
  logic tx_full, tx_empty, tx_pop, tx_can, tx_push, cpu_push, stop_req, stop_pending, stop_push;
  logic rx_full, rx_empty, rx_pop, rx_push;
  logic [7:0] tx_wdata, rx_head;

  assign a        = cpu_a[17:0];
  assign io       = a[17:16] == 2'b11;
  assign new_acc  = ~prev_v | (cpu_a != prev_a) | (cpu_wr != prev_wr);
  assign io_rd    = io & ~cpu_wr & new_acc;
  assign io_wr    = io & cpu_wr & new_acc;
  assign ram_a    = cpu_a[RAM_AW-1:0];
  assign ram_wr   = cpu_wr & ~io;
  assign ram_dout = cpu_dout;
  assign cpu_din  = sel_q ? io_rdata_q : (v_q ? ram_din : 8'h00);

  assign tx_cnt    = tx_wp - tx_rp;
  assign tx_full   = tx_cnt == DEPTH;
  assign tx_empty  = tx_cnt == '0;
  assign io_full   = tx_cnt >= DEPTH - ONE;
  assign tx_valid  = ~tx_empty;
  assign tx_data   = tx_empty ? 8'h00 : tx_mem[tx_rp[FIFO_LOG-1:0]];
  assign tx_pop    = tx_valid & tx_ready;
  assign tx_can    = ~tx_full | tx_pop;
  assign cpu_push  = io_wr & (a == 18'h30000) & (cpu_dout != 8'h00);
  assign stop_req  = io_wr & (a == 18'h30004);
  assign stop_push = ~cpu_push & (stop_req | stop_pending) & tx_can;
  assign tx_push   = (cpu_push & tx_can) | stop_push;
  assign tx_wdata  = cpu_push ? cpu_dout : 8'h00;

  assign rx_cnt   = rx_wp - rx_rp;
  assign rx_full  = rx_cnt == DEPTH;
  assign rx_empty = rx_cnt == '0;
  assign rx_head  = rx_mem[rx_rp[FIFO_LOG-1:0]];
  assign rx_pop   = io_rd & (a == 18'h30000) & ~rx_empty;
  assign rx_push  = rx_valid & (~rx_full | rx_pop);

  // IO read mux; 0x30004 returns the value being latched this cycle
  always_comb begin
    rd_data = (a == 18'h30000) ? (rx_empty ? 8'h00 : rx_head) :
              (a == 18'h30004) ? cnt[7:0] :
              (a == 18'h30005) ? snap[15:8] :
              (a == 18'h30006) ? snap[23:16] :
              (a == 18'h30007) ? snap[31:24] : 8'h00;
  end

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wp[FIFO_LOG-1:0]] <= tx_wdata;
    if (rx_push) rx_mem[rx_wp[FIFO_LOG-1:0]] <= rx_data;
  end

  // access tracking, read pipeline, counter, flags and FIFO pointers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_v       <= 1'b0;
      prev_a       <= '0;
      prev_wr      <= 1'b0;
      v_q          <= 1'b0;
      sel_q        <= 1'b0;
      io_rdata_q   <= '0;
      cnt          <= '0;
      snap         <= '0;
      program_stop <= 1'b0;
      tx_overflow  <= 1'b0;
      stop_pending <= 1'b0;
      tx_wp        <= '0;
      tx_rp        <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
    end else begin
      prev_v       <= 1'b1;
      prev_a       <= cpu_a;
      prev_wr      <= cpu_wr;
      v_q          <= 1'b1;
      sel_q        <= io;
      cnt          <= cnt + 32'd1;
      stop_pending <= (stop_req | stop_pending) & ~stop_push;
      if (io_rd) io_rdata_q <= rd_data;
      if (io_rd && a == 18'h30004) snap <= cnt;
      if (stop_req) program_stop <= 1'b1;
      if (cpu_push && !tx_can) tx_overflow <= 1'b1;
      if (tx_push) tx_wp <= tx_wp + ONE;
      if (tx_pop) tx_rp <= tx_rp + ONE;
      if (rx_push) rx_wp <= rx_wp + ONE;
      if (rx_pop) rx_rp <= rx_rp + ONE;
    end
  end
endmodule

// File: tb/tb_mmio_bus_hub.sv
// tb_mmio_bus_hub: table-driven and directed checks of the MMIO hub
module tb_mmio_bus_hub;
  logic clk = 0, rst = 1;
  logic [31:0] cpu_a = 0;
  logic cpu_wr = 0, tx_ready = 0, rx_valid = 0;
  logic [7:0] cpu_dout = 0, rx_data = 0, ram_din;
  logic [7:0] cpu_din, tx_data, ram_dout;
  logic io_full, ram_wr, tx_valid, program_stop, tx_overflow;
  logic [16:0] ram_a;
  logic [7:0] ram [1024];
  logic [31:0] tbcnt, e;
  int npass = 0, ntot = 0;

  typedef struct {
    logic [31:0] a; logic wr; logic [7:0] d; logic rdy; logic rxv; logic [7:0] rxd;
    logic cd; logic [7:0] din; logic txv; logic [7:0] txd;
  } vec_t;
  vec_t vq[$];

  mmio_bus_hub dut (
    .clk_in(clk), .rst_in(rst), .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .io_full(io_full), .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout),
    .ram_din(ram_din), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
    tbcnt <= rst ? 32'd0 : tbcnt + 32'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] na, input logic nwr, input logic [7:0] nd);
    cpu_a = na; cpu_wr = nwr; cpu_dout = nd;
  endtask

  task automatic add(input logic [31:0] na, input logic nwr, input logic [7:0] nd, input logic nrxv,
                     input logic [7:0] nrxd, input logic ncd, input logic [7:0] ndin,
                     input logic ntxv, input logic [7:0] ntxd);
    vec_t v;
    v.a = na; v.wr = nwr; v.d = nd; v.rdy = 1'b1; v.rxv = nrxv; v.rxd = nrxd;
    v.cd = ncd; v.din = ndin; v.txv = ntxv; v.txd = ntxd;
    vq.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    repeat (2) step();
    chk("rst cpu_din", cpu_din, 0);
    chk("rst io_full", io_full, 0);
    chk("rst tx_valid", tx_valid, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst program_stop", program_stop, 0);
    chk("rst tx_overflow", tx_overflow, 0);
    chk("rst ram_wr", ram_wr, 0);
    rst = 0;

    add(32'h100, 1, 8'h41, 0, 0, 0, 0, 0, 0);
    add(32'h100, 0, 0, 0, 0, 1, 8'h41, 0, 0);
    add(32'h30000, 1, 8'h48, 0, 0, 0, 0, 1, 8'h48);
    add(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(32'h30000, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(32'h30000, 1, 8'h49, 0, 0, 0, 0, 1, 8'h49);
    add(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(32'h0, 0, 0, 1, 8'h31, 1, 8'h00, 0, 0);
    add(32'h0, 0, 0, 1, 8'h32, 0, 0, 0, 0);
    add(32'h30000, 0, 0, 0, 0, 1, 8'h31, 0, 0);
    add(32'h30000, 0, 0, 0, 0, 1, 8'h31, 0, 0);
    add(32'h30000, 0, 0, 0, 0, 1, 8'h31, 0, 0);
    add(32'h0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
    add(32'h30000, 0, 0, 0, 0, 1, 8'h32, 0, 0);
    add(32'h0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
    add(32'h30000, 0, 0, 0, 0, 1, 8'h00, 0, 0);
    add(32'h0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
    add(32'h30000, 0, 0, 1, 8'h55, 1, 8'h00, 0, 0);
    add(32'h0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
    add(32'h30000, 0, 0, 0, 0, 1, 8'h55, 0, 0);
    add(32'h30008, 0, 0, 0, 0, 1, 8'h00, 0, 0);
    add(32'h30001, 0, 0, 0, 0, 1, 8'h00, 0, 0);
    add(32'h30008, 1, 8'h77, 0, 0, 0, 0, 0, 0);
    add(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      drv(vq[i].a, vq[i].wr, vq[i].d);
      tx_ready = vq[i].rdy; rx_valid = vq[i].rxv; rx_data = vq[i].rxd;
      #1;
      chk($sformatf("v%0d ram_wr", i), ram_wr, vq[i].wr && vq[i].a[17:16] != 2'b11);
      step();
      if (vq[i].cd) chk($sformatf("v%0d cpu_din", i), cpu_din, vq[i].din);
      chk($sformatf("v%0d tx_valid", i), tx_valid, vq[i].txv);
      if (vq[i].txv) chk($sformatf("v%0d tx_data", i), tx_data, vq[i].txd);
      chk($sformatf("v%0d io_full", i), io_full, 0);
      chk($sformatf("v%0d stop", i), program_stop, 0);
      chk($sformatf("v%0d ovf", i), tx_overflow, 0);
    end
    rx_valid = 0;

    tx_ready = 0;
    for (int i = 0; i < 8; i++) begin
      drv(32'h30000, 1, 8'h10 + 8'(i)); step();
      chk($sformatf("fill%0d io_full", i), io_full, i >= 6);
      drv(0, 0, 0); step();
    end
    drv(32'h30000, 1, 8'hEE); step();
    chk("overflow flag", tx_overflow, 1);
    chk("overflow head", tx_data, 8'h10);
    chk("overflow io_full", io_full, 1);
    drv(0, 0, 0); step();
    drv(32'h30004, 1, 0); step();
    chk("stop immediate", program_stop, 1);
    drv(0, 0, 0); step();
    tx_ready = 1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) chk("drain1 io_full", io_full, 1);
      if (k <= 8) begin
        chk($sformatf("drain%0d valid", k), tx_valid, 1);
        chk($sformatf("drain%0d data", k), tx_data, k == 8 ? 8'h00 : 8'h10 + 8'(k));
      end else chk("drain empty", tx_valid, 0);
    end
    chk("stop sticky", program_stop, 1);
    chk("ovf sticky", tx_overflow, 1);

    repeat (300) step();
    drv(32'h30004, 0, 0); e = tbcnt; step();
    chk("snap b0", cpu_din, e[7:0]);
    drv(32'h30005, 0, 0); step();
    chk("snap b1", cpu_din, e[15:8]);
    drv(32'h30006, 0, 0); step();
    chk("snap b2", cpu_din, e[23:16]);
    drv(32'h30007, 0, 0); step();
    chk("snap b3", cpu_din, e[31:24]);
    drv(0, 0, 0); repeat (300) step();
    drv(32'h30005, 0, 0); step();
    chk("snap not live", cpu_din, e[15:8]);
    drv(32'h30004, 0, 0); e = tbcnt; step();
    chk("snap relatch", cpu_din, e[7:0]);

    tx_ready = 0;
    drv(32'h30000, 1, 8'h5A); step();
    chk("pre-rst tx_valid", tx_valid, 1);
    drv(0, 0, 0); rx_valid = 1; rx_data = 8'h66; step();
    rx_valid = 0;
    drv(32'h30000, 1, 8'h5B); rst = 1; step();
    chk("mid-rst tx_valid", tx_valid, 0);
    chk("mid-rst stop", program_stop, 0);
    chk("mid-rst ovf", tx_overflow, 0);
    chk("mid-rst cpu_din", cpu_din, 0);
    rst = 0; step();
    chk("post-rst first push", tx_valid, 1);
    chk("post-rst first data", tx_data, 8'h5B);
    drv(0, 0, 0); step();
    drv(32'h30000, 0, 0); step();
    chk("post-rst rx flushed", cpu_din, 8'h00);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
